// File: rtl/lut_ram_be_if.sv
// Port bundle for lut_ram_be: clear request/status, port-0 read, port-1 read/write.
interface lut_ram_be_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 9
) ();
    logic                clr;
    logic                busy;
    logic [AWIDTH-1:0]   addr0;
    logic                ce0;
    logic [DWIDTH-1:0]   q0;
    logic                q0_valid;
    logic [AWIDTH-1:0]   addr1;
    logic                ce1;
    logic [DWIDTH/8-1:0] we1;
    logic [DWIDTH-1:0]   d1;
    logic [DWIDTH-1:0]   q1;
    logic                q1_valid;

    modport master (
        output clr, addr0, ce0, addr1, ce1, we1, d1,
        input  busy, q0, q0_valid, q1, q1_valid
    );

    modport slave (
        input  clr, addr0, ce0, addr1, ce1, we1, d1,
        output busy, q0, q0_valid, q1, q1_valid
    );
endinterface

// File: rtl/lut_ram_be.sv
// Dual-port distributed RAM with byte enables, collision bypass, optional
// output register and a zero-fill clear sequencer.
module lut_ram_be #(
    parameter int                DWIDTH         = 32,
    parameter int                AWIDTH         = 9,
    parameter int                MEM_SIZE       = 512,
    parameter int                OUT_REG        = 0,
    parameter int                BYPASS         = 1,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DWIDTH-1:0] CLEAR_VALUE    = '0
) (
    input logic         clk,
    input logic         rst,
    lut_ram_be_if.slave bus
);
    localparam int unsigned   NB    = DWIDTH / 8;
    localparam int            IW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [IW-1:0] LAST  = IW'(MEM_SIZE - 1);
    localparam logic [AWIDTH:0] LIMIT = (AWIDTH + 1)'(MEM_SIZE);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     cnt;
    logic              ready;

    logic [DWIDTH-1:0] mem [MEM_SIZE];

    logic              in0;
    logic              in1;
    logic [IW-1:0]     a0;
    logic [IW-1:0]     a1;
    logic              rd0;
    logic              rd1;
    logic              wr1;
    logic              hit;
    logic [DWIDTH-1:0] old0;
    logic [DWIDTH-1:0] data0;
    logic [DWIDTH-1:0] data1;

    logic [DWIDTH-1:0] s1_q0;
    logic [DWIDTH-1:0] s1_q1;
    logic              s1_v0;
    logic              s1_v1;

    // State register and clear-address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end else if (bus.clr) begin
                cnt <= '0;
            end
        end
    end

    // Next state: leave CLEAR after the last word, enter it on clr.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (cnt == LAST) state_nxt = READY;
            READY:   if (bus.clr)     state_nxt = CLEAR;
            default: state_nxt = READY;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ready    = (state == READY);
        bus.busy = (state == CLEAR);
    end

    // Request decode, range checks and the port-0 collision merge.
    always_comb begin
        a0    = bus.addr0[IW-1:0];
        a1    = bus.addr1[IW-1:0];
        in0   = ({1'b0, bus.addr0} < LIMIT);
        in1   = ({1'b0, bus.addr1} < LIMIT);
        rd0   = ready && bus.ce0;
        rd1   = ready && bus.ce1 && (bus.we1 == '0);
        wr1   = ready && bus.ce1 && (bus.we1 != '0) && in1;
        hit   = rd0 && wr1 && in0 && (bus.addr0 == bus.addr1);
        old0  = in0 ? mem[a0] : '0;
        data1 = in1 ? mem[a1] : '0;
        data0 = old0;
        if (hit && (BYPASS != 0)) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (bus.we1[b]) data0[8*b +: 8] = bus.d1[8*b +: 8];
            end
        end
    end

    // Array writes: clear fill takes the whole cycle, otherwise byte-masked port-1 writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= CLEAR_VALUE;
            end else if (wr1) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (bus.we1[b]) mem[a1][8*b +: 8] <= bus.d1[8*b +: 8];
                end
            end
        end
    end

    // First read stage: capture data on a read, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q0 <= '0;
            s1_q1 <= '0;
            s1_v0 <= 1'b0;
            s1_v1 <= 1'b0;
        end else begin
            s1_v0 <= rd0;
            s1_v1 <= rd1;
            if (rd0) s1_q0 <= data0;
            if (rd1) s1_q1 <= data1;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DWIDTH-1:0] s2_q0;
            logic [DWIDTH-1:0] s2_q1;
            logic              s2_v0;
            logic              s2_v1;

            // Second read stage: forwards only valid results so held data survives gaps.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_q0 <= '0;
                    s2_q1 <= '0;
                    s2_v0 <= 1'b0;
                    s2_v1 <= 1'b0;
                end else begin
                    s2_v0 <= s1_v0;
                    s2_v1 <= s1_v1;
                    if (s1_v0) s2_q0 <= s1_q0;
                    if (s1_v1) s2_q1 <= s1_q1;
                end
            end

            assign bus.q0       = s2_q0;
            assign bus.q1       = s2_q1;
            assign bus.q0_valid = s2_v0;
            assign bus.q1_valid = s2_v1;
        end else begin : g_noreg
            assign bus.q0       = s1_q0;
            assign bus.q1       = s1_q1;
            assign bus.q0_valid = s1_v0;
            assign bus.q1_valid = s1_v1;
        end
    endgenerate
endmodule

// File: tb/tb_lut_ram_be.sv
// Directed bench: instance A uses defaults, instance B uses OUT_REG=1,
// BYPASS=0, AWIDTH=10 and a non-zero clear word.
module tb_lut_ram_be;
    localparam logic [31:0] CV_B = 32'hC1EA_0001;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lut_ram_be_if #(.DWIDTH(32), .AWIDTH(9))  ia ();
    lut_ram_be_if #(.DWIDTH(32), .AWIDTH(10)) ib ();

    lut_ram_be #(
        .DWIDTH(32), .AWIDTH(9), .MEM_SIZE(512), .OUT_REG(0),
        .BYPASS(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
    ) u_a (.clk(clk), .rst(rst), .bus(ia));

    lut_ram_be #(
        .DWIDTH(32), .AWIDTH(10), .MEM_SIZE(512), .OUT_REG(1),
        .BYPASS(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV_B)
    ) u_b (.clk(clk), .rst(rst), .bus(ib));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ia.clr = 0; ia.ce0 = 0; ia.addr0 = '0; ia.ce1 = 0; ia.we1 = '0; ia.addr1 = '0; ia.d1 = '0;
    endtask

    task automatic idle_b();
        ib.clr = 0; ib.ce0 = 0; ib.addr0 = '0; ib.ce1 = 0; ib.we1 = '0; ib.addr1 = '0; ib.d1 = '0;
    endtask

    task automatic test_reset();
        int na = 0;
        int nb = 0;
        #1;
        checks++; if (ia.q0 !== 32'h0) begin errors++; $display("FAIL rst_a_q0 got=%h exp=%h", ia.q0, 32'h0); end
        checks++; if (ia.q1 !== 32'h0) begin errors++; $display("FAIL rst_a_q1 got=%h exp=%h", ia.q1, 32'h0); end
        checks++; if (ia.q0_valid !== 1'b0 || ia.q1_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got=%b%b exp=00", ia.q0_valid, ia.q1_valid); end
        checks++; if (ia.busy !== 1'b1) begin errors++; $display("FAIL rst_a_busy got=%b exp=1", ia.busy); end
        checks++; if (ib.busy !== 1'b1) begin errors++; $display("FAIL rst_b_busy got=%b exp=1", ib.busy); end
        checks++; if (ib.q0 !== 32'h0 || ib.q0_valid !== 1'b0) begin errors++; $display("FAIL rst_b_q0 got=%h/%b exp=0/0", ib.q0, ib.q0_valid); end
        tick();
        tick();
        rst = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!ia.busy && !ib.busy) break;
            if (ia.busy) na++;
            if (ib.busy) nb++;
            tick();
        end
        checks++; if (na != 512) begin errors++; $display("FAIL rst_a_busy_len got=%0d exp=512", na); end
        checks++; if (nb != 512) begin errors++; $display("FAIL rst_b_busy_len got=%0d exp=512", nb); end
    endtask

    task automatic test_read_zero();
        ia.ce0 = 1; ia.addr0 = 9'd0;
        tick();
        checks++; if (ia.q0 !== 32'h0 || ia.q0_valid !== 1'b1) begin errors++; $display("FAIL rd0_addr0 got=%h/%b exp=0/1", ia.q0, ia.q0_valid); end
        ia.addr0 = 9'd255;
        tick();
        checks++; if (ia.q0 !== 32'h0 || ia.q0_valid !== 1'b1) begin errors++; $display("FAIL rd0_addr255 got=%h/%b exp=0/1", ia.q0, ia.q0_valid); end
        ia.addr0 = 9'd511;
        tick();
        checks++; if (ia.q0 !== 32'h0 || ia.q0_valid !== 1'b1) begin errors++; $display("FAIL rd0_addr511 got=%h/%b exp=0/1", ia.q0, ia.q0_valid); end
        idle_a();
        tick();
        checks++; if (ia.q0_valid !== 1'b0) begin errors++; $display("FAIL rd0_strobe_end got=%b exp=0", ia.q0_valid); end
    endtask

    task automatic test_byte_we();
        ia.ce1 = 1; ia.we1 = 4'hF; ia.addr1 = 9'd5; ia.d1 = 32'hAABB_CCDD;
        tick();
        checks++; if (ia.q1_valid !== 1'b0) begin errors++; $display("FAIL wr_no_strobe got=%b exp=0", ia.q1_valid); end
        ia.we1 = 4'b0101; ia.d1 = 32'h1122_3344;
        tick();
        ia.we1 = 4'b0000; ia.d1 = 32'h0; ia.ce0 = 1; ia.addr0 = 9'd5;
        tick();
        checks++; if (ia.q1 !== 32'hAA22_CC44 || ia.q1_valid !== 1'b1) begin errors++; $display("FAIL be_q1 got=%h/%b exp=aa22cc44/1", ia.q1, ia.q1_valid); end
        checks++; if (ia.q0 !== 32'hAA22_CC44 || ia.q0_valid !== 1'b1) begin errors++; $display("FAIL be_q0 got=%h/%b exp=aa22cc44/1", ia.q0, ia.q0_valid); end
        idle_a();
        tick();
        checks++; if (ia.q1 !== 32'hAA22_CC44 || ia.q1_valid !== 1'b0) begin errors++; $display("FAIL be_q1_hold got=%h/%b exp=aa22cc44/0", ia.q1, ia.q1_valid); end
    endtask

    task automatic test_collision();
        ia.ce1 = 1; ia.we1 = 4'hF; ia.addr1 = 9'd7; ia.d1 = 32'hDEAD_BEEF; ia.ce0 = 1; ia.addr0 = 9'd7;
        tick();
        checks++; if (ia.q0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL coll_a_full got=%h exp=deadbeef", ia.q0); end
        ia.we1 = 4'b0011; ia.addr1 = 9'd8; ia.d1 = 32'h1234_5678; ia.addr0 = 9'd8;
        tick();
        checks++; if (ia.q0 !== 32'h0000_5678) begin errors++; $display("FAIL coll_a_merge got=%h exp=00005678", ia.q0); end
        idle_a();
        ib.ce1 = 1; ib.we1 = 4'hF; ib.addr1 = 10'd7; ib.d1 = 32'hDEAD_BEEF; ib.ce0 = 1; ib.addr0 = 10'd7;
        tick();
        idle_b();
        checks++; if (ib.q0_valid !== 1'b0) begin errors++; $display("FAIL coll_b_early got=%b exp=0", ib.q0_valid); end
        tick();
        checks++; if (ib.q0 !== CV_B || ib.q0_valid !== 1'b1) begin errors++; $display("FAIL coll_b_old got=%h/%b exp=%h/1", ib.q0, ib.q0_valid, CV_B); end
        ib.ce0 = 1; ib.addr0 = 10'd7;
        tick();
        idle_b();
        tick();
        checks++; if (ib.q0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL coll_b_after got=%h exp=deadbeef", ib.q0); end
    endtask

    task automatic test_out_reg();
        ib.ce1 = 1; ib.we1 = 4'hF;
        ib.addr1 = 10'd1; ib.d1 = 32'h1111_0001; tick();
        ib.addr1 = 10'd2; ib.d1 = 32'h2222_0002; tick();
        ib.addr1 = 10'd3; ib.d1 = 32'h3333_0003; tick();
        idle_b();
        tick();
        tick();
        ib.ce0 = 1; ib.addr0 = 10'd1;
        tick();
        checks++; if (ib.q0_valid !== 1'b0) begin errors++; $display("FAIL oreg_lat1 got=%b exp=0", ib.q0_valid); end
        ib.addr0 = 10'd2;
        tick();
        checks++; if (ib.q0 !== 32'h1111_0001 || ib.q0_valid !== 1'b1) begin errors++; $display("FAIL oreg_r1 got=%h/%b exp=11110001/1", ib.q0, ib.q0_valid); end
        ib.addr0 = 10'd3;
        tick();
        checks++; if (ib.q0 !== 32'h2222_0002 || ib.q0_valid !== 1'b1) begin errors++; $display("FAIL oreg_r2 got=%h/%b exp=22220002/1", ib.q0, ib.q0_valid); end
        idle_b();
        tick();
        checks++; if (ib.q0 !== 32'h3333_0003 || ib.q0_valid !== 1'b1) begin errors++; $display("FAIL oreg_r3 got=%h/%b exp=33330003/1", ib.q0, ib.q0_valid); end
        tick();
        checks++; if (ib.q0 !== 32'h3333_0003 || ib.q0_valid !== 1'b0) begin errors++; $display("FAIL oreg_hold got=%h/%b exp=33330003/0", ib.q0, ib.q0_valid); end
    endtask

    task automatic test_out_of_range();
        ib.ce1 = 1; ib.we1 = 4'hF; ib.addr1 = 10'd600; ib.d1 = 32'h1234_5678;
        tick();
        ib.we1 = 4'h0; ib.addr1 = 10'd88; ib.d1 = 32'h0; ib.ce0 = 1; ib.addr0 = 10'd600;
        tick();
        idle_b();
        tick();
        checks++; if (ib.q0 !== 32'h0 || ib.q0_valid !== 1'b1) begin errors++; $display("FAIL oor_read got=%h/%b exp=0/1", ib.q0, ib.q0_valid); end
        checks++; if (ib.q1 !== CV_B || ib.q1_valid !== 1'b1) begin errors++; $display("FAIL oor_alias got=%h/%b exp=%h/1", ib.q1, ib.q1_valid, CV_B); end
    endtask

    task automatic test_clear();
        int n  = 0;
        int nv = 0;
        ia.ce1 = 1; ia.we1 = 4'hF; ia.addr1 = 9'd511; ia.d1 = 32'h0BAD_F00D;
        tick();
        idle_a();
        ia.clr = 1; ia.ce0 = 1; ia.addr0 = 9'd511;
        tick();
        checks++; if (ia.q0 !== 32'h0BAD_F00D || ia.q0_valid !== 1'b1) begin errors++; $display("FAIL clr_same_cycle_read got=%h/%b exp=0badf00d/1", ia.q0, ia.q0_valid); end
        ia.clr = 0; ia.ce1 = 1; ia.we1 = 4'hF; ia.addr1 = 9'd3; ia.d1 = 32'hFFFF_FFFF;
        for (int i = 0; i < 2000; i++) begin
            if (!ia.busy) break;
            n++;
            if (i > 0 && (ia.q0_valid || ia.q1_valid)) nv++;
            tick();
        end
        idle_a();
        checks++; if (n != 512) begin errors++; $display("FAIL clr_busy_len got=%0d exp=512", n); end
        checks++; if (nv != 0) begin errors++; $display("FAIL clr_strobes_while_busy got=%0d exp=0", nv); end
        ia.ce0 = 1; ia.addr0 = 9'd3; ia.ce1 = 1; ia.addr1 = 9'd511;
        tick();
        checks++; if (ia.q0 !== 32'h0 || ia.q0_valid !== 1'b1) begin errors++; $display("FAIL clr_addr3 got=%h/%b exp=0/1", ia.q0, ia.q0_valid); end
        checks++; if (ia.q1 !== 32'h0 || ia.q1_valid !== 1'b1) begin errors++; $display("FAIL clr_addr511 got=%h/%b exp=0/1", ia.q1, ia.q1_valid); end
        ia.addr0 = 9'd5; ia.addr1 = 9'd7;
        tick();
        idle_a();
        checks++; if (ia.q0 !== 32'h0 || ia.q1 !== 32'h0) begin errors++; $display("FAIL clr_addr5_7 got=%h,%h exp=0,0", ia.q0, ia.q1); end
    endtask

    task automatic test_clear_inflight();
        int n  = 0;
        int nv = 0;
        ib.ce0 = 1; ib.addr0 = 10'd1; ib.clr = 1;
        tick();
        idle_b();
        checks++; if (ib.busy !== 1'b1) begin errors++; $display("FAIL inflight_busy got=%b exp=1", ib.busy); end
        tick();
        checks++; if (ib.q0 !== 32'h1111_0001 || ib.q0_valid !== 1'b1) begin errors++; $display("FAIL inflight_result got=%h/%b exp=11110001/1", ib.q0, ib.q0_valid); end
        ib.ce0 = 1; ib.addr0 = 10'd2;
        for (int i = 0; i < 2000; i++) begin
            if (!ib.busy) break;
            n++;
            if (i > 0 && ib.q0_valid) nv++;
            tick();
        end
        idle_b();
        checks++; if (n != 511) begin errors++; $display("FAIL inflight_busy_len got=%0d exp=511", n); end
        checks++; if (nv != 0) begin errors++; $display("FAIL inflight_strobes_while_busy got=%0d exp=0", nv); end
        ib.ce0 = 1; ib.addr0 = 10'd1;
        tick();
        idle_b();
        tick();
        checks++; if (ib.q0 !== CV_B || ib.q0_valid !== 1'b1) begin errors++; $display("FAIL b_clear_value got=%h/%b exp=%h/1", ib.q0, ib.q0_valid, CV_B); end
    endtask

    task automatic test_reset_midclear();
        int na = 0;
        int nb = 0;
        int nv = 0;
        ia.ce1 = 1; ia.we1 = 4'hF; ia.addr1 = 9'd9; ia.d1 = 32'h1357_9BDF;
        tick();
        ia.we1 = 4'h0; ia.ce0 = 1; ia.addr0 = 9'd9;
        tick();
        idle_a();
        ia.clr = 1;
        tick();
        ia.clr = 0;
        repeat (100) tick();
        ib.ce0 = 1; ib.addr0 = 10'd3;
        tick();
        idle_b();
        #2;
        rst = 1;
        #1;
        checks++; if (ia.q0 !== 32'h0 || ia.q1 !== 32'h0) begin errors++; $display("FAIL midrst_a_q got=%h,%h exp=0,0", ia.q0, ia.q1); end
        checks++; if (ib.q0 !== 32'h0 || ib.q0_valid !== 1'b0) begin errors++; $display("FAIL midrst_b_q0 got=%h/%b exp=0/0", ib.q0, ib.q0_valid); end
        checks++; if (ib.busy !== 1'b1) begin errors++; $display("FAIL midrst_b_busy got=%b exp=1", ib.busy); end
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!ia.busy && !ib.busy) break;
            if (ia.busy) na++;
            if (ib.busy) nb++;
            if (ia.q0_valid || ib.q0_valid) nv++;
            tick();
        end
        checks++; if (na != 512) begin errors++; $display("FAIL midrst_a_busy_len got=%0d exp=512", na); end
        checks++; if (nb != 512) begin errors++; $display("FAIL midrst_b_busy_len got=%0d exp=512", nb); end
        checks++; if (nv != 0) begin errors++; $display("FAIL midrst_inflight_dropped got=%0d exp=0", nv); end
        ia.ce0 = 1; ia.addr0 = 9'd9;
        tick();
        idle_a();
        checks++; if (ia.q0 !== 32'h0 || ia.q0_valid !== 1'b1) begin errors++; $display("FAIL midrst_addr9 got=%h/%b exp=0/1", ia.q0, ia.q0_valid); end
    endtask

    initial begin
        rst = 1;
        idle_a();
        idle_b();
        test_reset();
        test_read_zero();
        test_byte_we();
        test_collision();
        test_out_reg();
        test_out_of_range();
        test_clear();
        test_clear_inflight();
        test_reset_midclear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lut_ram_be.md
# lut_ram_be

Parametrised dual-port distributed-RAM buffer: the next generation of the plain LUT scratch RAM used by the MobileNetV1 layer engines. It adds per-byte write enables, a configurable read-during-write bypass, an optional output register stage with read-valid strobes, and a hardware clear sequencer that zero-fills the array after reset or on request. It is intended for per-layer bias, scale and partial-sum scratch storage between the DMA front end and the PE array.

## Interface
- DWIDTH, 32, data width in bits; must be a multiple of 8.
- AWIDTH, 9, address width.
- MEM_SIZE, 512, number of words; MEM_SIZE ≤ 2^AWIDTH.
- OUT_REG, 0, 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- BYPASS, 1, 1 makes port 0 return write-first data on a port-1 write collision; 0 returns old data.
- CLEAR_ON_RESET, 1, 1 runs the clear sequence after every reset.
- CLEAR_VALUE, 0, DWIDTH-bit fill word.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  request a clear sequence; sampled only in READY.
- busy  out  1  clear sequence in progress; all port requests are ignored while high.
- addr0  in  AWIDTH  port-0 read address.
- ce0  in  1  port-0 read enable.
- q0  out  DWIDTH  port-0 read data.
- q0_valid  out  1  one-cycle strobe marking new q0 data.
- addr1  in  AWIDTH  port-1 address.
- ce1  in  1  port-1 enable.
- we1  in  DWIDTH/8  port-1 byte write enables; any bit set makes the access a write, all zero makes it a read.
- d1  in  DWIDTH  port-1 write data.
- q1  out  DWIDTH  port-1 read data.
- q1_valid  out  1  one-cycle strobe marking new q1 data.

## Operation
- Storage is a distributed (LUT) RAM of MEM_SIZE words. The array contents are not affected by rst itself.
- FSM has two states, CLEAR and READY.
  - rst forces CLEAR when CLEAR_ON_RESET=1, otherwise READY. The clear counter resets to 0.
  - In CLEAR, each cycle writes CLEAR_VALUE to ram[cnt] and increments cnt. After the write to MEM_SIZE-1, the FSM moves to READY.
  - In READY, clr=1 moves the FSM to CLEAR with cnt=0. Port requests sampled in that same cycle are still executed.
- busy = (state == CLEAR).
- ce0, ce1, we1 and clr are ignored while busy. No valid strobes are issued while busy.
- Port-1 write: for each byte b with we1[b]=1, ram[addr1][8b+7:8b] ← d1[8b+7:8b]. q1 holds its value and q1_valid stays 0.
- Port-1 read (we1=0): q1 ← ram[addr1]; q1_valid pulses.
- Port-0 read: q0 ← ram[addr0]; q0_valid pulses.
- Out-of-range address (≥ MEM_SIZE):
  - A read returns 0 with valid still pulsed.
  - A write is dropped.
- Collision: port-0 read and port-1 write to the same address in the same cycle.
  - BYPASS=1: q0 returns the merged word, with new bytes where we1 is set and old bytes elsewhere.
  - BYPASS=0: q0 returns the pre-write word.
- When no read occurs, q0 and q1 hold their last value.

## Timing
- Reset values: q0 = 0, q1 = 0, q0_valid = 0, q1_valid = 0, busy = CLEAR_ON_RESET, internal output-stage registers = 0.
- Read latency:
  - OUT_REG=0: data and valid appear on the first rising edge after the sampled request.
  - OUT_REG=1: data and valid appear on the second rising edge. Back-to-back reads sustain one result per cycle.
- Write-to-read:
  - A port-0 or port-1 read issued the cycle after a write sees the new data.
  - A same-cycle port-0 read follows the BYPASS rule.
- Clear timing:
  - busy stays high for exactly MEM_SIZE rising edges after reset release or after the clr edge.
  - The first request is accepted in the cycle busy reads 0.
- clr raised during an OUT_REG=1 read: in-flight results still emerge with their valid strobe.
- rst asserted mid-clear or mid-read:
  - All outputs return immediately to their reset values.
  - In-flight reads are discarded.
  - The clear restarts from address 0 (if CLEAR_ON_RESET=1).

## Test plan
- Reset release with defaults: busy is high for 512 cycles. Afterwards, port-0 reads of addresses 0, 255 and 511 return 0 with a q0_valid pulse 1 cycle after ce0.
- Port-1 writes 0xAABBCCDD to address 5 with we1=4'b1111, then with we1=4'b0101 and d1=0x11223344: a subsequent read returns 0xAA22CC44.
- Collision: address 7 holds 0x0; same-cycle port-0 read of 7 and port-1 write of 0xDEADBEEF.
  - BYPASS=1: q0 = 0xDEADBEEF.
  - BYPASS=0: q0 = 0x0.
- OUT_REG=1: port-0 reads of addresses 1, 2, 3 on consecutive cycles return data on cycles +2, +3, +4 with q0_valid high for three consecutive cycles.
- Fill memory, pulse clr: busy is high for 512 cycles, requests during busy produce no valid strobes, and reads afterwards return CLEAR_VALUE.
- Assert rst at clear count 100: outputs go to 0 asynchronously, and busy then lasts a full 512 cycles after release. With AWIDTH=10 and MEM_SIZE=512, a write to address 600 is dropped and a read of address 600 returns 0.
